mat_result_streamer: RTL
========================

# mat_result_streamer

Output-side companion to the matrix memory bank. When the MAC array finishes a product (the bank's `unload_res` pulse), this block captures the up-to-3x3 result matrix in parallel, then streams it out one element per transfer over a valid/ready interface, row-major. It is the parallel-to-serial counterpart of the bank's serial-in load path and is the accelerator's only result egress.

## Interface
- `DATA_W`, 10: result element width (4b x 4b products, 3-term sum).
- `clk`  in  1  system clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `capture`  in  1  one-cycle pulse: `res_in` and dims are valid this cycle (driven from `unload_res`).
- `row_res`  in  2  result rows (= W rows), legal 1..3.
- `col_res`  in  2  result columns (= X columns), legal 1..3.
- `res_in`  in  9*DATA_W  result matrix, element (i,j) at bits `[(3*i+j)*DATA_W +: DATA_W]`.
- `data_out`  out  DATA_W  current element.
- `data_valid`  out  1  `data_out` is valid.
- `data_ready`  in  1  downstream accepts.
- `data_last`  out  1  current element is (rows-1, cols-1).
- `data_par`  out  1  parity of `data_out` (see Configuration).
- `busy`  out  1  stream in progress.
- `overrun`  out  1  sticky: a capture was dropped.

## Operation
- States: IDLE, STREAM.
- Capture is accepted when state is IDLE, or when state is STREAM and the final transfer (`data_valid & data_ready & data_last`) is in the same cycle. Both dims must be nonzero; otherwise the capture is ignored and the state is unchanged.
- On an accepted capture:
  - latch all 9 elements, `row_res` and `col_res` into internal registers;
  - clear indices r=0, c=0;
  - go to STREAM;
  - clear `overrun`.
- `capture` in STREAM, when not coincident with the final transfer, is dropped and sets `overrun`. The buffer is untouched.
- STREAM:
  - `data_valid=1`, `data_out=buf[r][c]`, `busy=1`;
  - on handshake, c++; when c==cols-1, c=0 and r++;
  - `data_last` = (r==rows-1 && c==cols-1);
  - handshake with `data_last` goes to IDLE, unless a capture is accepted in the same cycle, which re-enters STREAM.
- `data_out`, `data_last` and `data_par` hold stable while `data_valid & ~data_ready`.
- IDLE: `data_valid=0`, `data_last=0`, `busy=0`, `data_out=0`.
- Indices are 2-bit. They never exceed dims-1; there is no wrap past the matrix.

## Timing
- Reset values:
  - state=IDLE;
  - `data_out`=0, `data_valid`=0, `data_last`=0, `data_par`=0, `busy`=0, `overrun`=0;
  - buffer and dims = 0.
- Reset mid-stream aborts immediately. No further elements are emitted.
- Latency: with `capture` at edge N, `data_valid` rises after edge N. The first element is transferable in cycle N+1.
- Throughput: one element per cycle when `data_ready`=1. A rows x cols stream completes in rows*cols cycles with no bubbles.
- Back-to-back capture on the final transfer gives zero idle cycles between matrices.
- All outputs are functions of registers only. `data_ready` has no combinational path to outputs.

## Configuration
- `RES_PARITY_EN` defined: `data_par` = XOR reduction of `data_out` (even parity), valid whenever `data_valid`=1, and 0 in IDLE.
- Not defined: `data_par` is tied 0 and no parity logic is built. The port remains so the interface is identical.

## Test plan
- 3x3 with elements 1..9 row-major, `data_ready`=1 -> `data_out` 1,2,…,9 on 9 consecutive cycles, `data_last` only with 9, then `busy`=0.
- 2x3 capture with `data_ready` toggling 1,0,1,0 -> each element held while ready=0; 6 transfers in order (0,0)..(1,2); `data_last` on (1,2).
- Capture with `row_res`=0, `col_res`=2 -> no `data_valid`, `busy`=0, `overrun`=0.
- Second capture at the 3rd transfer of a 3x3 -> `overrun`=1, the first matrix streams unchanged; the next accepted capture clears `overrun`.
- Capture coincident with the final transfer of a 1x1 (value 5), new 1x2 (7,8) -> stream 5,7,8 on 3 consecutive cycles with `data_valid` never dropping.
- `rst_n` low during element 4 of 3x3 -> all outputs 0 asynchronously. With `RES_PARITY_EN`, value 0x007 yields `data_par`=1 and 0x003 yields 0.

Source files
------------

// File: rtl/mat_result_streamer_if.sv
// Result stream bundle for mat_result_streamer: element, valid/ready handshake,
// last-element flag and parity bit.
interface mat_result_streamer_if #(
    parameter int DATA_W = 10
);
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              data_ready;
    logic              data_last;
    logic              data_par;

    modport master (
        output data_out,
        output data_valid,
        output data_last,
        output data_par,
        input  data_ready
    );

    modport slave (
        input  data_out,
        input  data_valid,
        input  data_last,
        input  data_par,
        output data_ready
    );
endinterface

// File: rtl/mat_result_streamer.sv
// Captures an up-to-3x3 result matrix in parallel and streams it row-major over valid/ready.
// Optional even parity on data_par is built only when RES_PARITY_EN is defined.
module mat_result_streamer #(
    parameter int DATA_W = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  capture,
    input  logic [1:0]            row_res,
    input  logic [1:0]            col_res,
    input  logic [9*DATA_W-1:0]   res_in,
    output logic                  busy,
    output logic                  overrun,
    mat_result_streamer_if.master stream
);
    typedef enum logic {IDLE, STREAM} state_t;

    state_t state_reg, state_next;
    logic [1:0] r_reg, r_next;
    logic [1:0] c_reg, c_next;
    logic [1:0] rows_reg, cols_reg;
    logic       overrun_reg, overrun_next;
    logic [8:0][DATA_W-1:0] buf_flat;

    logic handshake, last_elem, final_xfer, dims_ok, accept, drop;
    logic [3:0] elem_idx;

    assign dims_ok    = (row_res != 2'd0) && (col_res != 2'd0);
    assign handshake  = (state_reg == STREAM) && stream.data_ready;
    assign last_elem  = (state_reg == STREAM) && (r_reg == rows_reg - 2'd1) && (c_reg == cols_reg - 2'd1);
    assign final_xfer = handshake && last_elem;
    assign accept     = capture && dims_ok && ((state_reg == IDLE) || final_xfer);
    // Captures with illegal dims are ignored outright, so they never count as dropped.
    assign drop       = capture && dims_ok && (state_reg == STREAM) && !final_xfer;

    genvar gi;
    generate
        for (gi = 0; gi < 9; gi++) begin : gen_buf
            logic [DATA_W-1:0] elem_reg;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    elem_reg <= '0;
                end else if (accept) begin
                    elem_reg <= res_in[gi*DATA_W +: DATA_W];
                end
            end
            assign buf_flat[gi] = elem_reg;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rows_reg <= 2'd0;
            cols_reg <= 2'd0;
        end else if (accept) begin
            rows_reg <= row_res;
            cols_reg <= col_res;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            r_reg       <= 2'd0;
            c_reg       <= 2'd0;
            overrun_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            r_reg       <= r_next;
            c_reg       <= c_next;
            overrun_reg <= overrun_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        r_next       = r_reg;
        c_next       = c_reg;
        overrun_next = overrun_reg;
        if (accept) begin
            state_next   = STREAM;
            r_next       = 2'd0;
            c_next       = 2'd0;
            overrun_next = 1'b0;
        end else begin
            if (drop) begin
                overrun_next = 1'b1;
            end
            if (handshake) begin
                if (last_elem) begin
                    state_next = IDLE;
                    r_next     = 2'd0;
                    c_next     = 2'd0;
                end else if (c_reg == cols_reg - 2'd1) begin
                    c_next = 2'd0;
                    r_next = r_reg + 2'd1;
                end else begin
                    c_next = c_reg + 2'd1;
                end
            end
        end
    end

    assign elem_idx          = ({2'b00, r_reg} * 4'd3) + {2'b00, c_reg};
    assign stream.data_valid = (state_reg == STREAM);
    assign stream.data_last  = last_elem;
    assign stream.data_out   = (state_reg == STREAM) ? buf_flat[elem_idx] : '0;
    assign busy              = (state_reg == STREAM);
    assign overrun           = overrun_reg;

`ifdef RES_PARITY_EN
    assign stream.data_par = ^stream.data_out;
`else
    assign stream.data_par = 1'b0;
`endif
endmodule
